// File: rtl/udp_cmd_dispatcher_if.sv
// UDP RX payload byte stream feeding the command dispatcher; byte strobe only,
// the consumer must take every valid byte (no ready, no backpressure).
interface udp_cmd_dispatcher_if;
    logic        app_rx_data_valid;
    logic [7:0]  app_rx_data;
    logic [15:0] app_rx_data_length;

    modport master (
        output app_rx_data_valid,
        output app_rx_data,
        output app_rx_data_length
    );

    modport slave (
        input  app_rx_data_valid,
        input  app_rx_data,
        input  app_rx_data_length
    );
endinterface

// File: rtl/udp_cmd_dispatcher.sv
// Parses [MAGIC][OPCODE][ADDR][DATA..] packets into a shadow bank and commits it atomically;
// verdict is decided on the byte edge, applied and pulsed one cycle later; never backpressures.
module udp_cmd_dispatcher #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] MAGIC    = 8'hA5,
    parameter int         CNT_W    = 16
) (
    input  logic                  udp_rx_clk,
    input  logic                  reset,
    udp_cmd_dispatcher_if.slave   rx,
    output logic [8*NUM_REGS-1:0] reg_bank,
    output logic [3:0]            led_data_1,
    output logic [15:0]           dled,
    output logic                  pkt_done,
    output logic                  pkt_err,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      pkt_ok_cnt,
    output logic [CNT_W-1:0]      pkt_err_cnt
);
    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS9   = 9'(NUM_REGS);
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] ERR_MAGIC  = 2'd1;
    localparam logic [1:0] ERR_OPCODE = 2'd2;
    localparam logic [1:0] ERR_RANGE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPCODE,
        S_ADDR,
        S_DATA,
        S_DISCARD
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        op_q, op_d;
    logic [8:0]        ptr_q, ptr_d;
    logic [7:0]        shadow_q [NUM_REGS];
    logic [7:0]        shadow_d [NUM_REGS];
    logic [7:0]        active_q [NUM_REGS];
    logic [7:0]        active_d [NUM_REGS];
    logic              done_req_q, done_req_d;
    logic              err_req_q, err_req_d;
    logic [1:0]        err_req_code_q, err_req_code_d;
    logic              pkt_done_q, pkt_done_d;
    logic              pkt_err_q, pkt_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [15:0]       byte_idx;
    logic [15:0]       cur_len;
    logic              is_last;
    logic              opcode_ok;
    logic              fail;
    logic [1:0]        fail_code;
    logic              accept_last;

    // Byte 0 is the one arriving in IDLE; its length field is used before it is latched.
    always_comb begin
        byte_idx  = (state_q == S_IDLE) ? 16'd0 : cnt_q;
        cur_len   = (state_q == S_IDLE) ? rx.app_rx_data_length : len_q;
        is_last   = (cur_len == 16'd0) || (byte_idx == (cur_len - 16'd1));
        opcode_ok = (rx.app_rx_data == 8'h01) || (rx.app_rx_data == 8'h02) ||
                    (rx.app_rx_data == 8'h03);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        op_d           = op_q;
        ptr_d          = ptr_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        done_req_d     = 1'b0;
        err_req_d      = 1'b0;
        err_req_code_d = 2'd0;
        pkt_done_d     = 1'b0;
        pkt_err_d      = 1'b0;
        err_code_d     = err_code_q;
        ok_cnt_d       = ok_cnt_q;
        err_cnt_d      = err_cnt_q;
        fail           = 1'b0;
        fail_code      = 2'd0;
        accept_last    = 1'b0;

        // Apply the verdict taken on the previous edge; no DATA write can coincide
        // because the FSM is in IDLE or DISCARD by now.
        if (done_req_q) begin
            if (op_q == OP_CLEAR) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    active_d[i] = 8'h00;
                    shadow_d[i] = 8'h00;
                end
            end else begin
                active_d = shadow_q;
            end
            pkt_done_d = 1'b1;
            ok_cnt_d   = ok_cnt_q + CNT_W'(1);
            err_code_d = 2'd0;
        end
        if (err_req_q) begin
            shadow_d   = active_q;
            pkt_err_d  = 1'b1;
            err_code_d = err_req_code_q;
            err_cnt_d  = err_cnt_q + CNT_W'(1);
        end

        if (rx.app_rx_data_valid) begin
            cnt_d = byte_idx + 16'd1;
            if (state_q == S_IDLE) begin
                len_d = rx.app_rx_data_length;
            end
            case (state_q)
                S_IDLE: begin
                    if (rx.app_rx_data != MAGIC) begin
                        fail      = 1'b1;
                        fail_code = ERR_MAGIC;
                    end else if (is_last) begin
                        fail      = 1'b1;
                        fail_code = ERR_RANGE;
                    end else begin
                        state_d = S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    if (!opcode_ok) begin
                        fail      = 1'b1;
                        fail_code = ERR_OPCODE;
                    end else if (is_last) begin
                        fail      = 1'b1;
                        fail_code = ERR_RANGE;
                    end else begin
                        op_d    = rx.app_rx_data[1:0];
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    ptr_d = {1'b0, rx.app_rx_data};
                    if ((op_q == OP_WRITE) && ({1'b0, rx.app_rx_data} >= NREGS9)) begin
                        fail      = 1'b1;
                        fail_code = ERR_RANGE;
                    end else if (is_last) begin
                        accept_last = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (op_q == OP_WRITE) begin
                        if (ptr_q >= NREGS9) begin
                            fail      = 1'b1;
                            fail_code = ERR_RANGE;
                        end else begin
                            shadow_d[ptr_q[IDX_W-1:0]] = rx.app_rx_data;
                            ptr_d = ptr_q + 9'd1;
                        end
                    end
                    if (!fail && is_last) begin
                        accept_last = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (is_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (fail) begin
                err_req_d      = 1'b1;
                err_req_code_d = fail_code;
                state_d        = is_last ? S_IDLE : S_DISCARD;
            end else if (accept_last) begin
                done_req_d = 1'b1;
                state_d    = S_IDLE;
            end
        end
    end

    always_ff @(posedge udp_rx_clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 16'd0;
            len_q          <= 16'd0;
            op_q           <= 2'd0;
            ptr_q          <= 9'd0;
            done_req_q     <= 1'b0;
            err_req_q      <= 1'b0;
            err_req_code_q <= 2'd0;
            pkt_done_q     <= 1'b0;
            pkt_err_q      <= 1'b0;
            err_code_q     <= 2'd0;
            ok_cnt_q       <= '0;
            err_cnt_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= 8'h00;
                active_q[i] <= 8'h00;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            op_q           <= op_d;
            ptr_q          <= ptr_d;
            done_req_q     <= done_req_d;
            err_req_q      <= err_req_d;
            err_req_code_q <= err_req_code_d;
            pkt_done_q     <= pkt_done_d;
            pkt_err_q      <= pkt_err_d;
            err_code_q     <= err_code_d;
            ok_cnt_q       <= ok_cnt_d;
            err_cnt_q      <= err_cnt_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
        assign reg_bank[8*gi +: 8] = active_q[gi];
    end

    assign led_data_1 = active_q[0][7:4];

    if (NUM_REGS > 2) begin : g_dled_full
        assign dled = {active_q[1], active_q[2]};
    end else begin : g_dled_short
        assign dled = {active_q[1], 8'h00};
    end

    assign pkt_done    = pkt_done_q;
    assign pkt_err     = pkt_err_q;
    assign err_code    = err_code_q;
    assign pkt_ok_cnt  = ok_cnt_q;
    assign pkt_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_udp_cmd_dispatcher.sv
// Randomized packet stream against a packet-level reference model of the dispatcher.
module tb_udp_cmd_dispatcher;
    localparam int         NUM_REGS = 8;
    localparam logic [7:0] MAGIC    = 8'hA5;
    localparam int         CNT_W    = 16;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int          gidx;
        logic [63:0] regs;
        int          ok;
        int          err;
    } exp_t;

    logic        udp_rx_clk = 1'b0;
    logic        reset;
    logic [63:0] reg_bank;
    logic [3:0]  led_data_1;
    logic [15:0] dled;
    logic        pkt_done;
    logic        pkt_err;
    logic [1:0]  err_code;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_err_cnt;

    udp_cmd_dispatcher_if rx_if ();

    udp_cmd_dispatcher #(
        .NUM_REGS(NUM_REGS),
        .MAGIC   (MAGIC),
        .CNT_W   (CNT_W)
    ) dut (
        .udp_rx_clk (udp_rx_clk),
        .reset      (reset),
        .rx         (rx_if),
        .reg_bank   (reg_bank),
        .led_data_1 (led_data_1),
        .dled       (dled),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .pkt_ok_cnt (pkt_ok_cnt),
        .pkt_err_cnt(pkt_err_cnt)
    );

    always #5 udp_rx_clk = ~udp_rx_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int byte_cyc[$];
    exp_t exp_q[$];
    logic [7:0] m_regs [NUM_REGS];
    int m_ok;
    int m_err;

    always @(posedge udp_rx_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] flat_regs();
        logic [63:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ok  = 0;
        m_err = 0;
        exp_q.delete();
    endtask

    // Whole-packet verdict: which byte decides it, the error code, and the resulting bank.
    task automatic model_pkt(input bq_t b);
        int n;
        int code;
        int idx;
        int op;
        int addr;
        int nd;
        exp_t e;
        n = b.size();
        code = 0;
        idx = n - 1;
        if (b[0] != MAGIC) begin
            code = 1; idx = 0;
        end else if (n == 1) begin
            code = 3; idx = 0;
        end else begin
            op = int'(b[1]);
            if (op < 1 || op > 3) begin
                code = 2; idx = 1;
            end else if (n == 2) begin
                code = 3; idx = 1;
            end else begin
                addr = int'(b[2]);
                nd = n - 3;
                if (op == 1 && addr >= NUM_REGS) begin
                    code = 3; idx = 2;
                end else if (op == 1 && addr + nd > NUM_REGS) begin
                    code = 3; idx = 3 + NUM_REGS - addr;
                end else if (op == 1) begin
                    for (int i = 0; i < nd; i++) m_regs[addr + i] = b[3 + i];
                end else if (op == 2) begin
                    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
                end
            end
        end
        if (code == 0) m_ok++;
        else m_err++;
        e.is_err = (code != 0);
        e.code   = 2'(code);
        e.gidx   = byte_cyc.size() + idx;
        e.regs   = flat_regs();
        e.ok     = m_ok;
        e.err    = m_err;
        exp_q.push_back(e);
    endtask

    always @(negedge udp_rx_clk) begin
        exp_t e;
        if (pkt_done || pkt_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {62'd0, pkt_done, pkt_err}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {62'd0, pkt_done, pkt_err}, e.is_err ? 64'd1 : 64'd2);
                check("err_code", 64'(err_code), 64'(e.code));
                check("pulse_cycle", 64'(cyc), 64'(byte_cyc[e.gidx] + 1));
                check("reg_bank", reg_bank, e.regs);
                check("led_data_1", 64'(led_data_1), 64'(e.regs[7:4]));
                check("dled", 64'(dled), {48'd0, e.regs[15:8], e.regs[23:16]});
                check("ok_cnt", 64'(pkt_ok_cnt), 64'(16'(e.ok)));
                check("err_cnt", 64'(pkt_err_cnt), 64'(16'(e.err)));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge udp_rx_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [15:0] len);
        rx_if.app_rx_data_valid  = 1'b1;
        rx_if.app_rx_data        = d;
        rx_if.app_rx_data_length = len;
        @(posedge udp_rx_clk);
        #1;
        byte_cyc.push_back(cyc);
        rx_if.app_rx_data_valid = 1'b0;
        rx_if.app_rx_data       = 8'($urandom);
    endtask

    task automatic send_pkt(input bq_t b, input logic [15:0] len, input int min_gap, input int max_gap);
        model_pkt(b);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], len);
            if (i < b.size() - 1) idle($urandom_range(max_gap, min_gap));
        end
    endtask

    task automatic settle(input string tag);
        idle(4);
        check({tag, "_bank"}, reg_bank, flat_regs());
        check({tag, "_okc"}, 64'(pkt_ok_cnt), 64'(16'(m_ok)));
        check({tag, "_errc"}, 64'(pkt_err_cnt), 64'(16'(m_err)));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bq_t pkt;
        int  n;
        int  r;
        int  ok_before;
        reset = 1'b1;
        rx_if.app_rx_data_valid  = 1'b0;
        rx_if.app_rx_data        = 8'h00;
        rx_if.app_rx_data_length = 16'd0;
        model_reset();
        idle(3);
        reset = 1'b0;
        @(negedge udp_rx_clk);
        check("rst_bank", reg_bank, 64'd0);
        check("rst_okc", 64'(pkt_ok_cnt), 64'd0);
        check("rst_errc", 64'(pkt_err_cnt), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);
        check("rst_pulses", {62'd0, pkt_done, pkt_err}, 64'd0);
        check("rst_dled", 64'(dled), 64'd0);
        idle(1);

        pkt = '{8'hA5, 8'h01, 8'h01, 8'h12, 8'h34};
        send_pkt(pkt, 16'd5, 0, 0);
        settle("t1");
        check("t1_dled", 64'(dled), 64'h1234);
        check("t1_okc_const", 64'(pkt_ok_cnt), 64'd1);

        pkt = '{8'h5A, 8'h01, 8'h00, 8'hFF};
        send_pkt(pkt, 16'd4, 0, 0);
        settle("t2");
        check("t2_code", 64'(err_code), 64'd1);
        check("t2_reg0", 64'(reg_bank[7:0]), 64'd0);
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h7E};
        send_pkt(pkt, 16'd4, 0, 0);
        settle("t2b");
        check("t2b_led", 64'(led_data_1), 64'h7);

        pkt = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
        send_pkt(pkt, 16'd11, 0, 1);
        settle("t3load");
        pkt = '{8'hA5, 8'h01, 8'h06, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(pkt, 16'd6, 0, 0);
        settle("t3");
        check("t3_code", 64'(err_code), 64'd3);
        check("t3_reg67", 64'(reg_bank[63:48]), 64'h8776);
        pkt = '{8'hA5, 8'h03, 8'h00};
        send_pkt(pkt, 16'd3, 0, 0);
        settle("t3nop");

        pkt = '{8'hA5, 8'h02, 8'h00};
        send_pkt(pkt, 16'd3, 0, 0);
        settle("t4clr");
        check("t4_led", 64'(led_data_1), 64'd0);
        check("t4_code", 64'(err_code), 64'd0);
        pkt = '{8'hA5, 8'h01};
        send_pkt(pkt, 16'd2, 0, 0);
        settle("t4short");
        check("t4_code3", 64'(err_code), 64'd3);

        ok_before = int'(pkt_ok_cnt);
        pkt = '{8'hA5, 8'h01, 8'h03, 8'hC1, 8'hC2};
        send_pkt(pkt, 16'd5, 1, 3);
        pkt = '{8'hA5, 8'h01, 8'h05, 8'hD1};
        send_pkt(pkt, 16'd4, 1, 3);
        settle("t5");
        check("t5_ok2", 64'(pkt_ok_cnt), 64'(16'(ok_before + 2)));

        send_byte(8'hA5, 16'd8);
        send_byte(8'h01, 16'd8);
        send_byte(8'h00, 16'd8);
        do_reset();
        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        send_pkt(pkt, 16'd8, 0, 0);
        settle("t6");
        check("t6_bank0", reg_bank, 64'd0);
        check("t6_errc", 64'(pkt_err_cnt), 64'd1);

        for (int p = 0; p < 80; p++) begin
            pkt.delete();
            if ($urandom_range(9, 0) == 0) begin
                pkt.push_back(($urandom_range(1, 0) == 0) ? MAGIC : 8'($urandom));
                send_pkt(pkt, 16'd0, 0, 0);
            end else begin
                n = $urandom_range(12, 1);
                pkt.push_back(($urandom_range(9, 0) == 0) ? 8'($urandom) : MAGIC);
                r = $urandom_range(9, 0);
                pkt.push_back((r < 5) ? 8'h01 : (r < 7) ? 8'h02 : (r < 8) ? 8'h03 : 8'($urandom));
                pkt.push_back(8'($urandom_range(9, 0)));
                for (int i = 3; i < 12; i++) pkt.push_back(8'($urandom));
                while (pkt.size() > n) void'(pkt.pop_back());
                send_pkt(pkt, 16'(n), 0, 3);
            end
            if ($urandom_range(3, 0) == 0) settle("rnd");
            else idle($urandom_range(3, 0));
        end
        settle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
